// File: rtl/regfile_dump_if.sv
// rtl/regfile_dump_if.sv - control, regfile read-port and output-stream bundle for regfile_dump
interface regfile_dump_if;
    logic        start;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_index;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    modport master (
        input  start, rd1, rd2, out_ready,
        output a1, a2, out_valid, out_index, out_data, out_last, busy, done
    );

    modport slave (
        output start, rd1, rd2, out_ready,
        input  a1, a2, out_valid, out_index, out_data, out_last, busy, done
    );
endinterface

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - walks the 32 RV32 registers two per access and streams them out; REGFILE_DUMP_CHECKSUM_EN adds an XOR checksum beat
module regfile_dump (
    input  logic          clk,
    input  logic          reset,
    regfile_dump_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        SEND_LO,
        SEND_HI,
`ifdef REGFILE_DUMP_CHECKSUM_EN
        CHECK,
`endif
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  p;
    logic [3:0]  p_next;
    logic [31:0] buf_hi;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [31:0] acc;
`endif

    assign p_next = p + 4'd1;

    // Dump sequencer; out_data doubles as the low-register buffer since it is loaded in CAPTURE and held until its handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            p             <= 4'd0;
            buf_hi        <= 32'd0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc           <= 32'd0;
`endif
            bus.a1        <= 5'd0;
            bus.a2        <= 5'd0;
            bus.out_valid <= 1'b0;
            bus.out_index <= 6'd0;
            bus.out_data  <= 32'd0;
            bus.out_last  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        p        <= 4'd0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        acc      <= 32'd0;
`endif
                        bus.a1   <= 5'd0;
                        bus.a2   <= 5'd1;
                        bus.busy <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    bus.out_data  <= bus.rd1;
                    buf_hi        <= bus.rd2;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    acc           <= acc ^ bus.rd1 ^ bus.rd2;
`endif
                    bus.out_index <= {1'b0, p, 1'b0};
                    bus.out_last  <= 1'b0;
                    bus.out_valid <= 1'b1;
                    state         <= SEND_LO;
                end
                SEND_LO: begin
                    if (bus.out_ready) begin
                        bus.out_index <= {1'b0, p, 1'b1};
                        bus.out_data  <= buf_hi;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        bus.out_last  <= 1'b0;
`else
                        bus.out_last  <= (p == 4'd15);
`endif
                        state         <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (bus.out_ready) begin
                        if (p == 4'd15) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                            bus.out_index <= 6'd32;
                            bus.out_data  <= acc;
                            bus.out_last  <= 1'b1;
                            state         <= CHECK;
`else
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            bus.busy      <= 1'b0;
                            bus.done      <= 1'b1;
                            state         <= DONE;
`endif
                        end else begin
                            p             <= p_next;
                            bus.a1        <= {p_next, 1'b0};
                            bus.a2        <= {p_next, 1'b1};
                            bus.out_valid <= 1'b0;
                            state         <= ISSUE;
                        end
                    end
                end
`ifdef REGFILE_DUMP_CHECKSUM_EN
                CHECK: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        state         <= DONE;
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
